add_seq16: RTL

ADD_SEQ16 -- requirements
Module: add_seq16

---
 rtl/add_seq_pkg.sv | 26 ++
 rtl/add_slice4.sv | 31 +++
 rtl/add_seq16.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/add_seq_pkg.sv
//==============================================================================
// Module      : add_seq_pkg
// Description : Shared slice width, FSM state encoding and index-width helper
//               for the slice-serial adder/subtractor.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package add_seq_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a counter that must reach n-1; a single slice still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/add_slice4.sv
//==============================================================================
// Module      : add_slice4
// Description : 4-bit ripple-carry adder slice with carry in and carry out.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module add_slice4
    import add_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] i_a,
    input  logic [SLICE_W-1:0] i_b,
    input  logic               i_ci,
    output logic [SLICE_W-1:0] o_s,
    output logic               o_co
);

    logic [SLICE_W:0] w_c;

    assign w_c[0] = i_ci;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
        assign o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
        assign w_c[i+1] = (i_a[i] & i_b[i]) | (i_a[i] & w_c[i]) | (i_b[i] & w_c[i]);
    end

    assign o_co = w_c[SLICE_W];

endmodule

`default_nettype wire

// File: rtl/add_seq16.sv
//==============================================================================
// Module      : add_seq16
// Description : Slice-serial W-bit adder/subtractor; one shared 4-bit slice
//               processes one nibble per cycle, valid/ready on both sides.
//               Macro ADD_SEQ_SUB_EN enables subtraction via op.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module add_seq16
    import add_seq_pkg::*;
#(
    parameter int NSLICE = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SLICE_W*NSLICE-1:0] A,
    input  logic [SLICE_W*NSLICE-1:0] B,
    input  logic                      op,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SLICE_W*NSLICE-1:0] sum,
    output logic                      cout,
    output logic                      ovf,
    output logic                      zero
);

    localparam int W    = SLICE_W * NSLICE;
    localparam int IDXW = idx_width(NSLICE);
    localparam logic [IDXW-1:0] C_IDX_LAST = IDXW'(NSLICE - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic [W-1:0]      r_sum;
    logic [IDXW-1:0]   r_idx;
    logic              r_carry;
    logic              r_cout;
    logic              r_ovf;
    logic              r_zero;

    logic              w_sub;
    logic [W-1:0]      w_b_eff;
    logic              w_accept;
    logic              w_last;
    logic [SLICE_W-1:0] w_a_sl;
    logic [SLICE_W-1:0] w_b_sl;
    logic [SLICE_W-1:0] w_s_sl;
    logic              w_co_sl;
    logic [W-1:0]      w_sum_nxt;
    logic              w_in_ready;
    logic              w_out_valid;

`ifdef ADD_SEQ_SUB_EN
    assign w_sub = op;
`else
    // op is kept on the interface but has no effect in add-only builds.
    logic w_unused_op;
    assign w_unused_op = op;
    assign w_sub       = 1'b0;
`endif

    // Subtraction is A + ~B + 1: invert B here, inject the +1 as initial carry.
    assign w_b_eff  = w_sub ? ~B : B;
    assign w_accept = w_in_ready & in_valid;
    assign w_last   = (r_idx == C_IDX_LAST);

    // Select the current nibble of each operand.
    always_comb begin
        w_a_sl = '0;
        w_b_sl = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_a_sl = r_a[i*SLICE_W +: SLICE_W];
                w_b_sl = r_b[i*SLICE_W +: SLICE_W];
            end
        end
    end

    add_slice4 u_slice (
        .i_a  (w_a_sl),
        .i_b  (w_b_sl),
        .i_ci (r_carry),
        .o_s  (w_s_sl),
        .o_co (w_co_sl)
    );

    // Full result as it will look after this cycle's nibble is written back.
    always_comb begin
        w_sum_nxt = r_sum;
        for (int i = 0; i < NSLICE; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_sum_nxt[i*SLICE_W +: SLICE_W] = w_s_sl;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= A;
                        r_b     <= w_b_eff;
                        r_carry <= w_sub;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    r_sum   <= w_sum_nxt;
                    r_carry <= w_co_sl;
                    if (w_last) begin
                        r_idx  <= '0;
                        r_cout <= w_co_sl;
                        r_ovf  <= (r_a[W-1] == r_b[W-1]) && (w_sum_nxt[W-1] != r_a[W-1]);
                        r_zero <= (w_sum_nxt == '0);
                    end else begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule

`default_nettype wire
